// File: rtl/pci_arb_pkg.sv
// Shared definitions for the PCI bus arbiter: state encoding and default sizing.
package pci_arb_pkg;

  // Arbiter phases: GAP is the idle turnaround, GNT holds a grant waiting
  // for the owner to start, XFER tracks the owner's transaction.
  typedef enum logic [1:0] {
    ST_GAP  = 2'd0,
    ST_GNT  = 2'd1,
    ST_XFER = 2'd2
  } arb_state_t;

  // Idle-bus clocks a granted initiator gets before the grant is withdrawn.
  localparam int DEF_GNT_TIMEOUT = 16;

  // Owner index width; enough for the largest supported requester count (8).
  localparam int DEF_IDW = 3;

endpackage

// File: rtl/pci_arbiter_rr_pick.sv
// Combinational round-robin picker: lowest-index request scanning upward
// from ptr+1 and wrapping modulo NUM_REQ.
module rr_pick
  import pci_arb_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int IDW     = DEF_IDW
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IDW-1:0]     ptr,
  output logic [IDW-1:0]     winner,
  output logic               valid
);

  logic [2*NUM_REQ-1:0] req_dbl;
  logic [IDW:0]         shift_amt;
  logic [NUM_REQ-1:0]   rot;
  logic [IDW-1:0]       offset;
  logic [IDW:0]         sum;

  // Doubling the vector turns the wrap-around into a plain right shift so
  // position 0 of rot is the requester just after ptr.
  assign req_dbl   = {req, req};
  assign shift_amt = {1'b0, ptr} + (IDW+1)'(1);
  assign rot       = NUM_REQ'(req_dbl >> shift_amt);

  // Lowest set bit of the rotated vector is the highest-priority requester.
  always_comb begin
    offset = '0;
    valid  = 1'b0;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      if (rot[i]) begin
        offset = IDW'(i);
        valid  = 1'b1;
      end
    end
  end

  // Map the rotated position back to an absolute index; sum never exceeds
  // 2*NUM_REQ-1, so one conditional subtraction is the whole modulo.
  assign sum    = {1'b0, ptr} + {1'b0, offset} + (IDW+1)'(1);
  assign winner = (sum >= (IDW+1)'(NUM_REQ)) ? IDW'(sum - (IDW+1)'(NUM_REQ))
                                              : sum[IDW-1:0];

endmodule

// File: rtl/pci_arbiter.sv
// Central PCI bus arbiter: round-robin grants with parking, hidden
// arbitration during busy bus, one-clock idle turnaround and grant timeout.
module pci_arbiter
  import pci_arb_pkg::*;
#(
  parameter int NUM_REQ     = 4,
  parameter int PARK_ID     = 0,
  parameter int GNT_TIMEOUT = DEF_GNT_TIMEOUT,
  parameter int IDW         = DEF_IDW
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NUM_REQ-1:0] req_n,
  input  logic               frame,
  input  logic               irdy,
  output logic [NUM_REQ-1:0] gnt_n,
  output logic [IDW-1:0]     gnt_id,
  output logic               bus_busy,
  output logic               timeout_evt
);

  localparam int             CNT_W    = $clog2(GNT_TIMEOUT + 1);
  localparam logic [IDW-1:0] PARK     = IDW'(PARK_ID);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(GNT_TIMEOUT - 1);

  arb_state_t         state_reg, state_next;
  logic [IDW-1:0]     owner_reg, owner_next;
  logic [IDW-1:0]     ptr_reg, ptr_next;
  logic [CNT_W-1:0]   cnt_reg, cnt_next;
  logic               idle_d_reg;
  logic               busy_reg, busy_next;
  logic               toe_reg, toe_next;
  logic [NUM_REQ-1:0] gnt_n_reg, gnt_n_next;

  logic [NUM_REQ-1:0] req;
  logic [NUM_REQ-1:0] owner_sel;
  logic               bus_idle;
  logic               start;
  logic               any_req;
  logic               owner_req;
  logic               others_req;
  logic [IDW-1:0]     win_id;
  logic               win_valid;

  assign req        = ~req_n;
  assign bus_idle   = frame & irdy;
  // A new transaction is FRAME# falling on a bus that was idle last clock.
  assign start      = ~frame & idle_d_reg;
  assign any_req    = |req;
  assign owner_req  = |(req & owner_sel);
  assign others_req = |(req & ~owner_sel);

  genvar gi;
  generate
    for (gi = 0; gi < NUM_REQ; gi++) begin : g_sel
      assign owner_sel[gi]  = (owner_reg == IDW'(gi));
      // Grant decode from the next state keeps gnt_n a clean register output.
      assign gnt_n_next[gi] = ~((state_next != ST_GAP) && (owner_next == IDW'(gi)));
    end
  endgenerate

  rr_pick #(
    .NUM_REQ (NUM_REQ),
    .IDW     (IDW)
  ) u_pick (
    .req    (req),
    .ptr    (ptr_reg),
    .winner (win_id),
    .valid  (win_valid)
  );

  // Next-state, owner, pointer, timeout counter and busy flag.
  always_comb begin
    state_next = state_reg;
    owner_next = owner_reg;
    ptr_next   = ptr_reg;
    cnt_next   = cnt_reg;
    busy_next  = busy_reg & ~bus_idle;
    toe_next   = 1'b0;

    case (state_reg)
      ST_GAP: begin
        // Turnaround clock done; the chosen owner now receives its grant.
        state_next = ST_GNT;
        ptr_next   = owner_reg;
        cnt_next   = '0;
      end

      ST_GNT: begin
        if (start) begin
          state_next = ST_XFER;
          busy_next  = 1'b1;
          cnt_next   = '0;
        end else if (bus_idle && !owner_req && others_req) begin
          state_next = ST_GAP;
          owner_next = win_id;
          ptr_next   = win_id;
          cnt_next   = '0;
        end else if (bus_idle && owner_req) begin
          if (cnt_reg == CNT_LAST) begin
            // Owner sat on the grant too long: drop it to lowest priority.
            // ptr_reg already equals the owner, so win_id scans past it.
            state_next = ST_GAP;
            toe_next   = 1'b1;
            ptr_next   = owner_reg;
            owner_next = win_id;
            cnt_next   = '0;
          end else begin
            cnt_next = cnt_reg + CNT_W'(1);
          end
        end else if (!any_req) begin
          // Parked with nobody asking: never time out.
          cnt_next = '0;
        end
      end

      ST_XFER: begin
        if (win_valid && (win_id != owner_reg)) begin
          // Hidden arbitration: hand the grant over while the bus is busy.
          state_next = ST_GNT;
          owner_next = win_id;
          ptr_next   = win_id;
          cnt_next   = '0;
          busy_next  = ~bus_idle;
        end else if (bus_idle) begin
          // Transaction over; stay parked on the last owner.
          state_next = ST_GNT;
          cnt_next   = '0;
        end
      end

      default: begin
        state_next = ST_GAP;
      end
    endcase
  end

  // State and output registers; reset drops every grant immediately.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg  <= ST_GAP;
      owner_reg  <= PARK;
      ptr_reg    <= PARK;
      cnt_reg    <= '0;
      idle_d_reg <= 1'b1;
      busy_reg   <= 1'b0;
      toe_reg    <= 1'b0;
      gnt_n_reg  <= '1;
    end else begin
      state_reg  <= state_next;
      owner_reg  <= owner_next;
      ptr_reg    <= ptr_next;
      cnt_reg    <= cnt_next;
      idle_d_reg <= bus_idle;
      busy_reg   <= busy_next;
      toe_reg    <= toe_next;
      gnt_n_reg  <= gnt_n_next;
    end
  end

  assign gnt_n       = gnt_n_reg;
  assign gnt_id      = owner_reg;
  assign bus_busy    = busy_reg;
  assign timeout_evt = toe_reg;

endmodule

// File: tb/tb_pci_arbiter.sv
// Self-checking bench for pci_arbiter: directed scenarios plus random bus
// traffic, all compared against a behavioural arbitration model.
module tb_pci_arbiter;

  localparam int N    = 4;
  localparam int PARK = 0;
  localparam int TMO  = 16;
  localparam int IDW  = 3;

  logic           clk = 1'b0;
  logic           rst = 1'b1;
  logic [N-1:0]   req_n_d = '1;
  logic           frame_d = 1'b1;
  logic           irdy_d  = 1'b1;
  logic [N-1:0]   gnt_n;
  logic [IDW-1:0] gnt_id;
  logic           bus_busy;
  logic           timeout_evt;

  pci_arbiter #(
    .NUM_REQ     (N),
    .PARK_ID     (PARK),
    .GNT_TIMEOUT (TMO),
    .IDW         (IDW)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .req_n       (req_n_d),
    .frame       (frame_d),
    .irdy        (irdy_d),
    .gnt_n       (gnt_n),
    .gnt_id      (gnt_id),
    .bus_busy    (bus_busy),
    .timeout_evt (timeout_evt)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: observed %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  bit m_gap, m_xfer, m_busy, m_toe, m_prev_idle;
  int m_owner, m_ptr, m_wait;

  function automatic int rr_win(input logic [N-1:0] rq_n, input int from);
    for (int k = 1; k <= N; k++) begin
      int idx;
      idx = (from + k) % N;
      if (!rq_n[idx]) return idx;
    end
    return -1;
  endfunction

  task automatic model_reset();
    m_gap = 1; m_xfer = 0; m_busy = 0; m_toe = 0; m_prev_idle = 1;
    m_owner = PARK; m_ptr = PARK; m_wait = 0;
  endtask

  task automatic model_step();
    bit idle, start, own_req, others, any_req, nbusy;
    int w;
    idle    = frame_d & irdy_d;
    start   = !frame_d && m_prev_idle;
    own_req = (req_n_d[m_owner] == 1'b0);
    others  = 0;
    any_req = 0;
    for (int i = 0; i < N; i++) begin
      if (!req_n_d[i]) begin
        any_req = 1;
        if (i != m_owner) others = 1;
      end
    end
    nbusy = m_busy && !idle;
    m_toe = 0;
    if (m_gap) begin
      m_gap = 0; m_ptr = m_owner; m_wait = 0;
    end else if (!m_xfer) begin
      if (start) begin
        m_xfer = 1; nbusy = 1; m_wait = 0;
      end else if (idle && !own_req && others) begin
        w = rr_win(req_n_d, m_ptr);
        m_owner = w; m_ptr = w; m_gap = 1; m_wait = 0;
      end else if (idle && own_req) begin
        m_wait++;
        if (m_wait == TMO) begin
          m_toe = 1; m_ptr = m_owner;
          m_owner = rr_win(req_n_d, m_owner);
          m_gap = 1; m_wait = 0;
        end
      end else if (!any_req) begin
        m_wait = 0;
      end
    end else begin
      w = rr_win(req_n_d, m_ptr);
      if (w >= 0 && w != m_owner) begin
        m_owner = w; m_ptr = w; m_xfer = 0; m_wait = 0;
      end else if (idle) begin
        m_xfer = 0; m_wait = 0;
      end
    end
    m_busy = nbusy;
    m_prev_idle = idle;
  endtask

  // ---------------- clocked compare ----------------
  int           grant_q[$];
  logic [N-1:0] prev_gnt = '1;

  task automatic step();
    logic [N-1:0] exp_g;
    int lows;
    int own;
    @(posedge clk);
    model_step();
    #1;
    exp_g = m_gap ? {N{1'b1}} : ~(N'(1) << m_owner);
    check("gnt_n", gnt_n, exp_g);
    check("gnt_id", gnt_id, m_owner);
    check("bus_busy", bus_busy, m_busy);
    check("timeout_evt", timeout_evt, m_toe);
    lows = 0;
    own  = -1;
    for (int i = 0; i < N; i++) begin
      if (gnt_n[i] === 1'b0) begin
        lows++;
        own = i;
      end
    end
    check("one_grant", lows <= 1, 1);
    if (gnt_n !== prev_gnt && own >= 0) grant_q.push_back(own);
    prev_gnt = gnt_n;
  endtask

  // ---------------- bus master agent ----------------
  bit [N-1:0] want = '0;
  bit [N-1:0] lazy = '0;
  bit         act  = 0;
  int         left = 0;
  int         nphase = 3;

  task automatic agent_drive();
    if (act) begin
      left--;
      if (left > 1) begin
        frame_d = 1'b0; irdy_d = 1'b0;
      end else if (left == 1) begin
        frame_d = 1'b1; irdy_d = 1'b0;
      end else begin
        frame_d = 1'b1; irdy_d = 1'b1; act = 0;
      end
    end else if (frame_d && irdy_d && !m_gap && !m_xfer && want[m_owner] && !lazy[m_owner]) begin
      act = 1; left = nphase; frame_d = 1'b0; irdy_d = 1'b0;
      $display("txn: master %0d starts %0d-phase transfer at %0t", m_owner, nphase, $time);
    end
    req_n_d = ~want;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish at %0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    bit seen_busy;
    // ---- reset, no requests ----
    #1 rst = 1'b0;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    check("rst_gnt_n", gnt_n, 4'b1111);
    check("rst_gnt_id", gnt_id, PARK);
    check("rst_busy", bus_busy, 0);
    check("rst_toe", timeout_evt, 0);
    @(negedge clk);
    rst = 1'b1;
    #1 check("gap_after_rst", gnt_n, 4'b1111);
    step();
    step();
    check("park_gnt_n", gnt_n, 4'b1110);
    check("park_gnt_id", gnt_id, 0);

    // ---- master 1 requests while parked on 0 ----
    req_n_d = 4'b1101;
    step();
    check("req1_gap", gnt_n, 4'b1111);
    step();
    check("req1_gnt", gnt_n, 4'b1101);
    frame_d = 1'b0; irdy_d = 1'b0;
    step();
    check("m1_busy", bus_busy, 1);

    // ---- hidden arbitration during master 1's transfer ----
    req_n_d = 4'b1001;
    step();
    check("hidden_gnt", gnt_n, 4'b1011);
    check("hidden_busy", bus_busy, 1);
    frame_d = 1'b1; irdy_d = 1'b0;
    step();
    frame_d = 1'b1; irdy_d = 1'b1;
    step();
    check("m1_done_busy", bus_busy, 0);
    req_n_d = 4'b1111;
    frame_d = 1'b0; irdy_d = 1'b0;
    step();
    check("m2_start_busy", bus_busy, 1);
    frame_d = 1'b1; irdy_d = 1'b0;
    step();
    frame_d = 1'b1; irdy_d = 1'b1;
    step();
    check("m2_park_gnt", gnt_n, 4'b1011);

    // ---- master 3 granted but never starts ----
    req_n_d = 4'b0111;
    step();
    check("m3_gap", gnt_n, 4'b1111);
    step();
    check("m3_gnt", gnt_n, 4'b0111);
    req_n_d = 4'b0011;
    for (int i = 1; i <= TMO; i++) begin
      step();
      check("tmo_pulse", timeout_evt, (i == TMO) ? 1 : 0);
    end
    check("tmo_gap", gnt_n, 4'b1111);
    step();
    check("after_tmo_gnt", gnt_n, 4'b1011);

    // ---- everyone requesting, 3-phase transfers: rotation order ----
    want = '1; lazy = '0; nphase = 3;
    grant_q.delete();
    for (int c = 0; c < 80 && grant_q.size() < 4; c++) begin
      agent_drive();
      step();
    end
    check("order_len", grant_q.size() >= 4, 1);
    for (int k = 0; k < 4 && k < grant_q.size(); k++)
      check("rr_order", grant_q[k], (2 + 1 + k) % N);

    // ---- random traffic ----
    for (int c = 0; c < 2500; c++) begin
      if (c % 150 == 0)
        lazy = ($urandom_range(0, 2) == 0) ? (N'(1) << $urandom_range(0, N - 1)) : '0;
      for (int i = 0; i < N; i++)
        if ($urandom_range(0, 9) == 0) want[i] = ~want[i];
      nphase = int'($urandom_range(2, 4));
      agent_drive();
      step();
    end

    // ---- reset pulled while a transaction is in flight ----
    want = '1; lazy = '0;
    seen_busy = 0;
    for (int c = 0; c < 300 && !seen_busy; c++) begin
      agent_drive();
      step();
      seen_busy = m_busy;
    end
    check("busy_before_rst", bus_busy, 1);
    #3 rst = 1'b0;
    #1;
    check("async_rst_gnt", gnt_n, 4'b1111);
    check("async_rst_busy", bus_busy, 0);
    model_reset();
    act = 0; want = '0;
    frame_d = 1'b1; irdy_d = 1'b1; req_n_d = '1;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    step();
    step();
    check("repark_gnt_n", gnt_n, 4'b1110);
    check("repark_gnt_id", gnt_id, PARK);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
